// File: rtl/pf_clk_div_delay_ctrl.sv
// Command sequencer for the RX clock-divider delay line: spaced LOAD/MOVE pulses, tap tracking, range errors.
// Optional build macro CDD_OOR_SYNC_EN adds a 2-flop synchronizer on delay_line_out_of_range.
module pf_clk_div_delay_ctrl #(
  parameter int TAP_W    = 8,
  parameter int MAX_TAP  = 255,
  parameter int LOAD_VAL = 1,
  parameter int MOVE_GAP = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [TAP_W-1:0] cmd_steps,
  output logic             delay_line_dir,
  output logic             delay_line_move,
  output logic             delay_line_load,
  input  logic             delay_line_out_of_range,
  output logic [TAP_W-1:0] tap_count,
  output logic             busy,
  output logic             done,
  output logic             oor_err
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MOVE_GAP - 1);
  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] TAP_LOAD = TAP_W'(LOAD_VAL);
  localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_FIN} state_t;

  state_t           state_reg;
  logic [TAP_W-1:0] tap_reg;
  logic [TAP_W-1:0] steps_left_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             move_reg;
  logic             load_reg;
  logic             dir_reg;
  logic             oor_err_reg;
  logic             abort_reg;
  logic             blocked_reg;

  logic             oor_s;
  logic             accept;
  logic             step_up;
  logic             at_limit;
  logic [TAP_W-1:0] tap_step;

`ifdef CDD_OOR_SYNC_EN
  logic [1:0] oor_sync_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      oor_sync_reg <= 2'b00;
    end else begin
      oor_sync_reg <= {oor_sync_reg[0], delay_line_out_of_range};
    end
  end

  assign oor_s = oor_sync_reg[1];
`else
  assign oor_s = delay_line_out_of_range;
`endif

  // Direction of the step about to be attempted: the incoming op at accept, the held one afterwards.
  always_comb begin
    accept   = (state_reg == S_IDLE) && ready_reg && cmd_valid;
    step_up  = accept ? (cmd_op == OP_INC) : dir_reg;
    at_limit = step_up ? (tap_reg == TAP_MAX) : (tap_reg == '0);
    tap_step = step_up ? (tap_reg + TAP_ONE) : (tap_reg - TAP_ONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      tap_reg        <= TAP_LOAD;
      steps_left_reg <= '0;
      gap_cnt_reg    <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      move_reg       <= 1'b0;
      load_reg       <= 1'b0;
      dir_reg        <= 1'b0;
      oor_err_reg    <= 1'b0;
      abort_reg      <= 1'b0;
      blocked_reg    <= 1'b0;
    end else begin
      move_reg <= 1'b0;
      load_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
            dir_reg     <= (cmd_op == OP_INC);
            abort_reg   <= 1'b0;
            blocked_reg <= 1'b0;
            case (cmd_op)
              OP_LOAD: begin
                load_reg       <= 1'b1;
                tap_reg        <= TAP_LOAD;
                oor_err_reg    <= 1'b0;
                steps_left_reg <= '0;
                state_reg      <= S_PULSE;
              end
              OP_INC, OP_DEC: begin
                if (cmd_steps == '0) begin
                  done_reg  <= 1'b1;
                  state_reg <= S_FIN;
                end else if (at_limit) begin
                  // Hold a pulse slot without a MOVE so the cell never steps past its end.
                  oor_err_reg <= 1'b1;
                  blocked_reg <= 1'b1;
                  state_reg   <= S_PULSE;
                end else begin
                  move_reg       <= 1'b1;
                  tap_reg        <= tap_step;
                  steps_left_reg <= cmd_steps - TAP_ONE;
                  state_reg      <= S_PULSE;
                end
              end
              OP_NOP: begin
                done_reg  <= 1'b1;
                state_reg <= S_FIN;
              end
              default: begin
                done_reg  <= 1'b1;
                state_reg <= S_FIN;
              end
            endcase
          end else begin
            ready_reg <= 1'b1;
          end
        end
        S_PULSE: begin
          if (blocked_reg) begin
            done_reg  <= 1'b1;
            state_reg <= S_FIN;
          end else begin
            gap_cnt_reg <= GAP_INIT;
            state_reg   <= S_GAP;
          end
        end
        S_GAP: begin
          if (oor_s) begin
            oor_err_reg <= 1'b1;
            abort_reg   <= 1'b1;
          end
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end else if (abort_reg || oor_s || (steps_left_reg == '0)) begin
            done_reg  <= 1'b1;
            state_reg <= S_FIN;
          end else if (at_limit) begin
            oor_err_reg <= 1'b1;
            blocked_reg <= 1'b1;
            state_reg   <= S_PULSE;
          end else begin
            move_reg       <= 1'b1;
            tap_reg        <= tap_step;
            steps_left_reg <= steps_left_reg - TAP_ONE;
            state_reg      <= S_PULSE;
          end
        end
        S_FIN: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // DIR reflects the offered op during the accept cycle, then the value captured at accept.
  assign delay_line_dir  = (ready_reg && cmd_valid) ? (cmd_op == OP_INC) : dir_reg;
  assign delay_line_move = move_reg;
  assign delay_line_load = load_reg;
  assign cmd_ready       = ready_reg;
  assign tap_count       = tap_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign oor_err         = oor_err_reg;

endmodule
